// File: rtl/crack_scheduler_if.sv
// Bundle of the job-control and worker-fabric signals of crack_scheduler.
// The slave side is the scheduler; the master side is whoever issues jobs
// and hosts the brute-force workers.
interface crack_scheduler_if #(
    parameter int NUM_WORKERS = 4
);
    localparam int WW = $clog2(NUM_WORKERS);

    // Job control
    logic                       start;
    logic [31:0]                password;
    logic                       busy;
    logic                       done;
    logic                       pw_found;
    logic [WW-1:0]              found_worker;
    logic [5:0]                 found_from;

    // Worker fabric
    logic [31:0]                w_pwd;
    logic [NUM_WORKERS-1:0]     w_rst;
    logic [6*NUM_WORKERS-1:0]   w_from;
    logic [6*NUM_WORKERS-1:0]   w_to;
    logic [NUM_WORKERS-1:0]     w_found;
    logic [NUM_WORKERS-1:0]     w_done;

    modport master (
        output start, password, w_found, w_done,
        input  busy, done, pw_found, found_worker, found_from,
               w_pwd, w_rst, w_from, w_to
    );

    modport slave (
        input  start, password, w_found, w_done,
        output busy, done, pw_found, found_worker, found_from,
               w_pwd, w_rst, w_from, w_to
    );
endinterface

// File: rtl/crack_scheduler.sv
// crack_scheduler: hands out first-symbol ranges of a 4-character password
// search to a pool of brute-force workers, round-robin, and reports which
// worker (and which range) found the match, or that the space ran out.
module crack_scheduler #(
    parameter int NUM_WORKERS = 4,
    parameter int CHUNK       = 9,
    parameter int MAX_SYM     = 35
) (
    input  logic              clk,
    input  logic              rst,
    crack_scheduler_if.slave  bus
);
    localparam int WW = $clog2(NUM_WORKERS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [7:0] MAX_SYM_8  = 8'(MAX_SYM);
    localparam logic [7:0] CHUNK_M1_8 = 8'(CHUNK - 1);
    localparam logic [6:0] CHUNK_7    = 7'(CHUNK);

    // Worker flags are untrusted for the w_rst cycle and the one after;
    // this is the number of cycles to ignore them after a dispatch.
    localparam logic [1:0] HOLD_INIT = 2'd2;

    // Control state
    logic [1:0]                    state;
    logic [6:0]                    next_from;
    logic [WW-1:0]                 rr_ptr;
    logic [NUM_WORKERS-1:0]        wk_busy;
    logic [NUM_WORKERS-1:0][1:0]   hold;

    // Output registers
    logic                          busy_q;
    logic                          done_q;
    logic                          pw_found_q;
    logic [WW-1:0]                 found_worker_q;
    logic [5:0]                    found_from_q;
    logic [31:0]                   w_pwd_q;
    logic [NUM_WORKERS-1:0]        w_rst_q;
    logic [NUM_WORKERS-1:0][5:0]   from_q;
    logic [NUM_WORKERS-1:0][5:0]   to_q;

    // Decision signals
    logic [NUM_WORKERS-1:0]        sampled;
    logic [NUM_WORKERS-1:0]        match_vec;
    logic [NUM_WORKERS-1:0]        free_vec;
    logic [NUM_WORKERS-1:0]        free_after;
    logic [2*NUM_WORKERS-1:0]      free2;
    logic [2*NUM_WORKERS-1:0]      rot;
    logic [WW-1:0]                 match_idx;
    logic [5:0]                    match_from;
    logic                          disp_valid;
    logic [WW-1:0]                 disp_idx;
    logic [WW:0]                   scan_sum;
    logic [NUM_WORKERS-1:0]        disp_onehot;
    logic [WW-1:0]                 rr_nxt;
    logic [7:0]                    to_sum;
    logic [7:0]                    to_val;
    logic                          exhausted;
    logic                          do_match;
    logic                          do_disp;
    logic                          do_exhaust;

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pw_found     = pw_found_q;
    assign bus.found_worker = found_worker_q;
    assign bus.found_from   = found_from_q;
    assign bus.w_pwd        = w_pwd_q;
    assign bus.w_rst        = w_rst_q;
    assign bus.w_from       = from_q;
    assign bus.w_to         = to_q;

    // Per-cycle decision: which workers are sampled, match/free detection,
    // round-robin pick of the next free worker, and the range to hand out.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        sampled     = '0;
        match_idx   = '0;
        match_from  = '0;
        disp_valid  = 1'b0;
        disp_idx    = '0;
        scan_sum    = '0;
        disp_onehot = '0;

        for (int i = 0; i < NUM_WORKERS; i++) begin
            sampled[i] = wk_busy[i] && (hold[i] == 2'd0);
        end
        match_vec  = sampled & bus.w_found;
        free_vec   = sampled & bus.w_done & ~bus.w_found;
        free_after = ~wk_busy | free_vec;

        // Descending scan so the lowest matching index is the one kept.
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_idx  = WW'(i);
                match_from = from_q[i];
            end
        end

        // Rotate the free map so bit 0 is the worker at rr_ptr, then take
        // the first set bit and map it back to an absolute index.
        free2 = {free_after, free_after};
        rot   = free2 >> rr_ptr;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (!disp_valid && rot[k]) begin
                disp_valid = 1'b1;
                scan_sum   = {1'b0, rr_ptr} + (WW+1)'(k);
                if (scan_sum >= (WW+1)'(NUM_WORKERS)) begin
                    scan_sum = scan_sum - (WW+1)'(NUM_WORKERS);
                end
                disp_idx = scan_sum[WW-1:0];
            end
        end
        for (int i = 0; i < NUM_WORKERS; i++) begin
            disp_onehot[i] = (disp_idx == WW'(i));
        end
        rr_nxt = (disp_idx == WW'(NUM_WORKERS - 1)) ? '0 : disp_idx + WW'(1);

        exhausted = {1'b0, next_from} > MAX_SYM_8;
        to_sum    = {1'b0, next_from} + CHUNK_M1_8;
        to_val    = (to_sum > MAX_SYM_8) ? MAX_SYM_8 : to_sum;

        do_match   = (state == RUN) && (|match_vec);
        do_disp    = (state == RUN) && !(|match_vec) && disp_valid && !exhausted;
        do_exhaust = (state == RUN) && !(|match_vec) && exhausted && (&free_after);
    end

    // Scheduler state, worker bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            next_from      <= '0;
            rr_ptr         <= '0;
            wk_busy        <= '0;
            // NOTE: hold is a handful of flops, not a RAM, so it is cleared
            // by reset like any other control register.
            hold           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pw_found_q     <= 1'b0;
            found_worker_q <= '0;
            found_from_q   <= '0;
            w_pwd_q        <= '0;
            w_rst_q        <= '1;
            from_q         <= '0;
            to_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every statement
            // sees pre-edge values and later defaults can be overridden below.
            w_rst_q <= '0;
            done_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= RUN;
                        busy_q         <= 1'b1;
                        w_pwd_q        <= bus.password;
                        pw_found_q     <= 1'b0;
                        found_worker_q <= '0;
                        found_from_q   <= '0;
                        next_from      <= '0;
                        rr_ptr         <= '0;
                        wk_busy        <= '0;
                        hold           <= '0;
                    end
                end

                RUN: begin
                    for (int i = 0; i < NUM_WORKERS; i++) begin
                        if (hold[i] != 2'd0) begin
                            hold[i] <= hold[i] - 2'd1;
                        end
                    end

                    if (do_match) begin
                        state          <= FINISH;
                        done_q         <= 1'b1;
                        w_rst_q        <= '1;
                        pw_found_q     <= 1'b1;
                        found_worker_q <= match_idx;
                        found_from_q   <= match_from;
                    end else if (do_disp) begin
                        wk_busy   <= (wk_busy & ~free_vec) | disp_onehot;
                        w_rst_q   <= disp_onehot;
                        next_from <= next_from + CHUNK_7;
                        rr_ptr    <= rr_nxt;
                        for (int i = 0; i < NUM_WORKERS; i++) begin
                            if (disp_onehot[i]) begin
                                from_q[i] <= next_from[5:0];
                                to_q[i]   <= to_val[5:0];
                                hold[i]   <= HOLD_INIT;
                            end
                        end
                    end else if (do_exhaust) begin
                        state   <= FINISH;
                        done_q  <= 1'b1;
                        w_rst_q <= '1;
                        wk_busy <= '0;
                    end else begin
                        wk_busy <= wk_busy & ~free_vec;
                    end
                end

                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: a default 4-worker instance and a
// 2-worker/CHUNK=5 instance, worker flags driven by hand.
module tb_crack_scheduler;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crack_scheduler_if #(.NUM_WORKERS(4)) bus_a();
    crack_scheduler_if #(.NUM_WORKERS(2)) bus_b();

    crack_scheduler #(.NUM_WORKERS(4), .CHUNK(9), .MAX_SYM(35)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    crack_scheduler #(.NUM_WORKERS(2), .CHUNK(5), .MAX_SYM(35)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven before are seen at the rising edge,
    // outputs are read at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] slice6(input logic [47:0] v, input int i);
        logic [47:0] s;
        s = v >> (6 * i);
        return s[5:0];
    endfunction

    initial begin
        int w;
        int exp_to;

        rst            = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.password = '0;
        bus_a.w_found  = '0;
        bus_a.w_done   = '0;
        bus_b.start    = 1'b0;
        bus_b.password = '0;
        bus_b.w_found  = '0;
        bus_b.w_done   = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_busy",  bus_a.busy, 0);
        check("rst_done",  bus_a.done, 0);
        check("rst_w_rst", bus_a.w_rst, 4'b1111);
        check("rst_w_pwd", bus_a.w_pwd, 0);
        check("rst_from",  bus_a.w_from, 0);
        rst = 1'b0;
        step();
        check("idle_w_rst", bus_a.w_rst, 0);
        check("idle_busy",  bus_a.busy, 0);

        // ---------------- job 1: "0000", worker 0 matches ----------------
        bus_a.start    = 1'b1;
        bus_a.password = 32'h3030_3030;
        step();
        bus_a.start = 1'b0;
        check("j1_busy",  bus_a.busy, 1);
        check("j1_w_pwd", bus_a.w_pwd, 32'h3030_3030);
        check("j1_w_rst0", bus_a.w_rst, 0);
        step();
        check("j1_rst_w0", bus_a.w_rst, 4'b0001);
        check("j1_from0",  slice6(bus_a.w_from, 0), 0);
        check("j1_to0",    slice6(bus_a.w_to, 0), 8);
        step();
        check("j1_rst_w1", bus_a.w_rst, 4'b0010);
        check("j1_from1",  slice6(bus_a.w_from, 1), 9);
        check("j1_to1",    slice6(bus_a.w_to, 1), 17);
        step();
        check("j1_rst_w2", bus_a.w_rst, 4'b0100);
        check("j1_from2",  slice6(bus_a.w_from, 2), 18);
        check("j1_to2",    slice6(bus_a.w_to, 2), 26);
        step();
        check("j1_rst_w3", bus_a.w_rst, 4'b1000);
        check("j1_from3",  slice6(bus_a.w_from, 3), 27);
        check("j1_to3",    slice6(bus_a.w_to, 3), 35);
        check("j1_from0_held", slice6(bus_a.w_from, 0), 0);
        step();
        check("j1_no_disp", bus_a.w_rst, 0);
        check("j1_busy_run", bus_a.busy, 1);
        bus_a.w_found = 4'b0001;
        step();
        bus_a.w_found = '0;
        check("j1_done",     bus_a.done, 1);
        check("j1_pw_found", bus_a.pw_found, 1);
        check("j1_fworker",  bus_a.found_worker, 0);
        check("j1_ffrom",    bus_a.found_from, 0);
        check("j1_halt",     bus_a.w_rst, 4'b1111);
        step();
        check("j1_done_off", bus_a.done, 0);
        check("j1_idle",     bus_a.busy, 0);
        check("j1_held",     bus_a.pw_found, 1);

        // ---------------- job 2: early w_done ignored, then exhaustion ----
        bus_a.start    = 1'b1;
        bus_a.password = 32'h3939_3939;
        step();
        bus_a.start = 1'b0;
        check("j2_pw_cleared", bus_a.pw_found, 0);
        step();
        check("j2_rst_w0", bus_a.w_rst, 4'b0001);
        bus_a.w_done = 4'b0001;
        step();
        check("j2_rst_w1", bus_a.w_rst, 4'b0010);
        step();
        bus_a.w_done = '0;
        check("j2_rst_w2", bus_a.w_rst, 4'b0100);
        step();
        check("j2_rst_w3", bus_a.w_rst, 4'b1000);
        step();
        bus_a.w_done = 4'b1110;
        step();
        check("j2_w0_still_busy_done", bus_a.done, 0);
        check("j2_w0_still_busy_busy", bus_a.busy, 1);
        bus_a.w_done = 4'b1111;
        step();
        bus_a.w_done = '0;
        check("j2_exh_done",  bus_a.done, 1);
        check("j2_exh_found", bus_a.pw_found, 0);
        check("j2_exh_halt",  bus_a.w_rst, 4'b1111);
        step();
        check("j2_idle", bus_a.busy, 0);

        // ---------------- job 3: start ignored in RUN, dual match --------
        bus_a.start    = 1'b1;
        bus_a.password = 32'h3132_3334;
        step();
        bus_a.start = 1'b0;
        check("j3_w_pwd", bus_a.w_pwd, 32'h3132_3334);
        step();
        check("j3_rst_w0", bus_a.w_rst, 4'b0001);
        bus_a.start    = 1'b1;
        bus_a.password = 32'h4141_4141;
        step();
        bus_a.start = 1'b0;
        check("j3_rst_w1", bus_a.w_rst, 4'b0010);
        step();
        check("j3_pwd_kept", bus_a.w_pwd, 32'h3132_3334);
        check("j3_rst_w2",   bus_a.w_rst, 4'b0100);
        check("j3_from2",    slice6(bus_a.w_from, 2), 18);
        step();
        check("j3_rst_w3", bus_a.w_rst, 4'b1000);
        step();
        bus_a.w_found = 4'b1010;
        step();
        bus_a.w_found = '0;
        check("j3_done",    bus_a.done, 1);
        check("j3_found",   bus_a.pw_found, 1);
        check("j3_fworker", bus_a.found_worker, 1);
        check("j3_ffrom",   bus_a.found_from, 9);
        step();
        check("j3_idle", bus_a.busy, 0);

        // ---------------- job 4: reset mid-job, then restart ------------
        bus_a.start    = 1'b1;
        bus_a.password = 32'h4142_4344;
        step();
        bus_a.start = 1'b0;
        check("j4_fworker_cleared", bus_a.found_worker, 0);
        check("j4_ffrom_cleared",   bus_a.found_from, 0);
        step();
        step();
        step();
        check("j4_rst_w2", bus_a.w_rst, 4'b0100);
        rst = 1'b1;
        #1;
        check("j4_rst_busy",  bus_a.busy, 0);
        check("j4_rst_done",  bus_a.done, 0);
        check("j4_rst_w_rst", bus_a.w_rst, 4'b1111);
        check("j4_rst_pwd",   bus_a.w_pwd, 0);
        check("j4_rst_from",  bus_a.w_from, 0);
        check("j4_rst_to",    bus_a.w_to, 0);
        check("j4_rst_found", bus_a.pw_found, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("j4_rel_w_rst", bus_a.w_rst, 0);
        bus_a.start    = 1'b1;
        bus_a.password = 32'h3030_3030;
        step();
        bus_a.start = 1'b0;
        check("j4_restart_busy", bus_a.busy, 1);
        step();
        check("j4_restart_rst_w0", bus_a.w_rst, 4'b0001);
        check("j4_restart_from0",  slice6(bus_a.w_from, 0), 0);
        check("j4_restart_to0",    slice6(bus_a.w_to, 0), 8);

        // ---------------- 2 workers, CHUNK=5, no match ------------------
        bus_b.start    = 1'b1;
        bus_b.password = 32'h5830_3030;
        step();
        bus_b.start = 1'b0;
        check("b_busy", bus_b.busy, 1);
        step();
        check("b_rst_k0",  bus_b.w_rst, 2'b01);
        check("b_from_k0", slice6(bus_b.w_from, 0), 0);
        check("b_to_k0",   slice6(bus_b.w_to, 0), 4);
        step();
        check("b_rst_k1",  bus_b.w_rst, 2'b10);
        check("b_from_k1", slice6(bus_b.w_from, 1), 5);
        check("b_to_k1",   slice6(bus_b.w_to, 1), 9);
        step();
        check("b_idle_gap", bus_b.w_rst, 0);
        for (int k = 2; k < 8; k++) begin
            w = k % 2;
            exp_to = 5 * k + 4;
            if (exp_to > 35) exp_to = 35;
            bus_b.w_done = 2'(1 << w);
            step();
            bus_b.w_done = '0;
            check($sformatf("b_rst_k%0d", k),  bus_b.w_rst, 64'(1 << w));
            check($sformatf("b_from_k%0d", k), slice6(bus_b.w_from, w), 64'(5 * k));
            check($sformatf("b_to_k%0d", k),   slice6(bus_b.w_to, w), 64'(exp_to));
            step();
            check($sformatf("b_gap_k%0d", k), bus_b.w_rst, 0);
        end
        step();
        check("b_not_done_yet", bus_b.done, 0);
        bus_b.w_done = 2'b11;
        step();
        bus_b.w_done = '0;
        check("b_done",  bus_b.done, 1);
        check("b_found", bus_b.pw_found, 0);
        check("b_halt",  bus_b.w_rst, 2'b11);
        step();
        check("b_done_off", bus_b.done, 0);
        check("b_idle",     bus_b.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
